rps_match_engine: RTL and testbench

//  Registered, parametrised rock-paper-scissors match controller. Scores successive

---
 rtl/rps_match_engine.sv | 190 +++++++++++++++++++
 tb/tb_rps_match_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_match_engine.sv
// ---------------------------------------------------------------------------
// rps_match_engine
//   Registered rock-paper-scissors match controller. Each round_valid strobe
//   scores moves A and B. The first player to reach WIN_TARGET round wins
//   takes the match. The engine then sits in OVER until new_match is pulsed.
//   Score digits are decoded combinationally for two 7-segment displays.
//
// Ports
//   CLK          in   system clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   A, B         in   moves: 00 rock, 01 paper, 10 scissors, 11 invalid
//   round_valid  in   1-cycle strobe, A/B hold a round to score
//   new_match    in   1-cycle strobe, clear scores and restart
//   result       out  00 tie, 01 A wins, 10 B wins, 11 invalid round
//   result_valid out  1-cycle pulse when result is updated
//   Acounter     out  rounds won by A
//   Bcounter     out  rounds won by B
//   round_cnt    out  rounds scored this match (saturating)
//   match_over   out  high while in OVER
//   winner       out  00 none, 01 A, 10 B
//   seg7A, seg7B out  hex digit of the low nibble of each counter, bit0 = seg a
//   fsm_state    out  current FSM state (0 PLAY, 1 OVER) for observation
//
// Handshake: a round is accepted on every rising edge where round_valid is
// high, the FSM is in PLAY and new_match is low. There is no back-pressure,
// so one round per cycle is sustained. new_match takes priority over
// round_valid in the same cycle.
// ---------------------------------------------------------------------------
module rps_match_engine #(
    parameter int CNT_W          = 4,
    parameter int WIN_TARGET     = 3,
    parameter int ROUND_W        = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [1:0]         A,
    input  logic [1:0]         B,
    input  logic               round_valid,
    input  logic               new_match,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic [CNT_W-1:0]   Acounter,
    output logic [CNT_W-1:0]   Bcounter,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               match_over,
    output logic [1:0]         winner,
    output logic [0:6]         seg7A,
    output logic [0:6]         seg7B,
    output logic               fsm_state
);

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]   TARGET    = CNT_W'(WIN_TARGET);
    localparam logic [ROUND_W-1:0] ROUND_MAX = '1;

    state_t             state;
    logic [1:0]         round_res;
    logic [CNT_W-1:0]   a_inc;
    logic [CNT_W-1:0]   b_inc;
    logic [3:0]         digit_a;
    logic [3:0]         digit_b;

    assign a_inc     = Acounter + CNT_W'(1);
    assign b_inc     = Bcounter + CNT_W'(1);
    assign fsm_state = state;

    // Round outcome: each move beats the one encoded just below it, modulo 3.
    always_comb begin
        round_res = 2'b00;
        if (A == 2'b11 || B == 2'b11) begin
            round_res = 2'b11;
        end else if (A == B) begin
            round_res = 2'b00;
        end else if ((A == 2'b01 && B == 2'b00) ||
                     (A == 2'b10 && B == 2'b01) ||
                     (A == 2'b00 && B == 2'b10)) begin
            round_res = 2'b01;
        end else begin
            round_res = 2'b10;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= PLAY;
            result       <= 2'b00;
            result_valid <= 1'b0;
            Acounter     <= '0;
            Bcounter     <= '0;
            round_cnt    <= '0;
            match_over   <= 1'b0;
            winner       <= 2'b00;
        end else if (new_match) begin
            state        <= PLAY;
            result       <= 2'b00;
            result_valid <= 1'b0;
            Acounter     <= '0;
            Bcounter     <= '0;
            round_cnt    <= '0;
            match_over   <= 1'b0;
            winner       <= 2'b00;
        end else begin
            case (state)
                PLAY: begin
                    result_valid <= round_valid;
                    if (round_valid) begin
                        result <= round_res;
                        if (round_cnt != ROUND_MAX) begin
                            round_cnt <= round_cnt + ROUND_W'(1);
                        end
                        if (round_res == 2'b01) begin
                            Acounter <= a_inc;
                            // Reaching the target ends the match on the same
                            // edge that publishes the deciding round.
                            if (a_inc == TARGET) begin
                                state      <= OVER;
                                match_over <= 1'b1;
                                winner     <= 2'b01;
                            end
                        end else if (round_res == 2'b10) begin
                            Bcounter <= b_inc;
                            if (b_inc == TARGET) begin
                                state      <= OVER;
                                match_over <= 1'b1;
                                winner     <= 2'b10;
                            end
                        end
                    end
                end
                OVER: begin
                    result_valid <= 1'b0;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

    // Only the low nibble of each counter is displayed. Narrow counters are
    // zero-extended.
    generate
        if (CNT_W >= 4) begin : g_digit_slice
            assign digit_a = Acounter[3:0];
            assign digit_b = Bcounter[3:0];
        end else begin : g_digit_ext
            assign digit_a = {{(4 - CNT_W){1'b0}}, Acounter};
            assign digit_b = {{(4 - CNT_W){1'b0}}, Bcounter};
        end
    endgenerate

    // Active-high segment pattern, listed left to right as a..g.
    function automatic logic [0:6] hex_to_seg(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    always_comb begin
        seg7A = hex_to_seg(digit_a);
        seg7B = hex_to_seg(digit_b);
        if (SEG_ACTIVE_LOW) begin
            seg7A = ~seg7A;
            seg7B = ~seg7B;
        end
    end

endmodule

// File: tb/tb_rps_match_engine.sv
// ---------------------------------------------------------------------------
// tb_rps_match_engine
//   Self-checking bench for rps_match_engine. Drivers update a reference model
//   and push the expected output snapshot for every round that should be
//   scored. A monitor pops one snapshot per result_valid pulse and compares
//   it. Scenario tasks add inline checks for reset, OVER and new_match
//   behaviour.
// ---------------------------------------------------------------------------
module tb_rps_match_engine;

    localparam int CNT_W      = 4;
    localparam int WIN_TARGET = 3;
    localparam int ROUND_W    = 6;
    localparam int W          = 2 + CNT_W + CNT_W + ROUND_W + 1 + 2 + 7 + 7;

    // ---------------- clock / reset ----------------
    logic               CLK;
    logic               RST_N;
    logic [1:0]         A;
    logic [1:0]         B;
    logic               round_valid;
    logic               new_match;
    logic [1:0]         result;
    logic               result_valid;
    logic [CNT_W-1:0]   Acounter;
    logic [CNT_W-1:0]   Bcounter;
    logic [ROUND_W-1:0] round_cnt;
    logic               match_over;
    logic [1:0]         winner;
    logic [0:6]         seg7A;
    logic [0:6]         seg7B;
    logic               fsm_state;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    rps_match_engine #(
        .CNT_W(CNT_W),
        .WIN_TARGET(WIN_TARGET),
        .ROUND_W(ROUND_W),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .A(A),
        .B(B),
        .round_valid(round_valid),
        .new_match(new_match),
        .result(result),
        .result_valid(result_valid),
        .Acounter(Acounter),
        .Bcounter(Bcounter),
        .round_cnt(round_cnt),
        .match_over(match_over),
        .winner(winner),
        .seg7A(seg7A),
        .seg7B(seg7B),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard / model ----------------
    int             checks    = 0;
    int             fails     = 0;
    int             rv_pulses = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   mon_exp;
    logic [W-1:0]   mon_obs;

    logic [CNT_W-1:0]   m_a;
    logic [CNT_W-1:0]   m_b;
    logic [ROUND_W-1:0] m_rounds;
    logic               m_over;
    logic [1:0]         m_win;

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;  4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;  default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    task automatic model_clear();
        m_a      = '0;
        m_b      = '0;
        m_rounds = '0;
        m_over   = 1'b0;
        m_win    = 2'b00;
    endtask

    // Reference scoring: (a - b) mod 3 is 1 when A wins and 2 when B wins.
    task automatic model_round(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        int         d;
        if (m_over) return;
        if (m_rounds != {ROUND_W{1'b1}}) m_rounds = m_rounds + 1'b1;
        if (a == 2'b11 || b == 2'b11) begin
            r = 2'b11;
        end else begin
            d = (int'(a) - int'(b) + 3) % 3;
            r = (d == 0) ? 2'b00 : ((d == 1) ? 2'b01 : 2'b10);
        end
        if (r == 2'b01) m_a = m_a + 1'b1;
        if (r == 2'b10) m_b = m_b + 1'b1;
        if (int'(m_a) == WIN_TARGET) begin
            m_over = 1'b1;
            m_win  = 2'b01;
        end else if (int'(m_b) == WIN_TARGET) begin
            m_over = 1'b1;
            m_win  = 2'b10;
        end
        exp_q.push_back({r, m_a, m_b, m_rounds, m_over, m_win, seg_ref(m_a), seg_ref(m_b)});
    endtask

    always @(negedge CLK) begin
        if (RST_N && result_valid) begin
            rv_pulses++;
            checks++;
            mon_obs = {result, Acounter, Bcounter, round_cnt, match_over, winner, seg7A, seg7B};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result_valid: got pulse with result=%b, expected no pulse", result);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    fails++;
                    $display("FAIL round_snapshot: got %h expected %h", mon_obs, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_round(input logic [1:0] a, input logic [1:0] b);
        @(negedge CLK);
        A = a;
        B = b;
        round_valid = 1'b1;
        model_round(a, b);
        @(negedge CLK);
        round_valid = 1'b0;
    endtask

    task automatic new_match_pulse();
        @(negedge CLK);
        new_match = 1'b1;
        @(negedge CLK);
        new_match = 1'b0;
        model_clear();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST_N = 1'b0;
        A = 2'b00;
        B = 2'b00;
        round_valid = 1'b0;
        new_match = 1'b0;
        model_clear();
        #12;
        checks++;
        if ({result, result_valid, Acounter, Bcounter, round_cnt, match_over, winner, fsm_state}
            !== {2'b00, 1'b0, 4'd0, 4'd0, 6'd0, 1'b0, 2'b00, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got res=%b rv=%b a=%0d b=%0d rc=%0d mo=%b w=%b st=%b, expected all zero",
                     result, result_valid, Acounter, Bcounter, round_cnt, match_over, winner, fsm_state);
        end
        checks++;
        if (seg7A !== 7'b1111110 || seg7B !== 7'b1111110) begin
            fails++;
            $display("FAIL reset_seg: got %b/%b expected 1111110/1111110", seg7A, seg7B);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_a_wins_round();
        drive_round(2'b01, 2'b00);
        checks++;
        if (result_valid !== 1'b1 || result !== 2'b01 || Acounter !== 4'd1 || round_cnt !== 6'd1) begin
            fails++;
            $display("FAIL a_wins_round: got rv=%b res=%b a=%0d rc=%0d expected 1 01 1 1",
                     result_valid, result, Acounter, round_cnt);
        end
        checks++;
        if (seg7A !== 7'b0110000) begin
            fails++;
            $display("FAIL a_wins_seg: got %b expected 0110000", seg7A);
        end
    endtask

    task automatic test_tie_invalid();
        drive_round(2'b10, 2'b10);
        checks++;
        if (result !== 2'b00) begin
            fails++;
            $display("FAIL tie_result: got %b expected 00", result);
        end
        drive_round(2'b11, 2'b00);
        checks++;
        if (result !== 2'b11 || Acounter !== 4'd1 || Bcounter !== 4'd0 || round_cnt !== 6'd3) begin
            fails++;
            $display("FAIL invalid_round: got res=%b a=%0d b=%0d rc=%0d expected 11 1 0 3",
                     result, Acounter, Bcounter, round_cnt);
        end
    endtask

    task automatic test_reset_mid_match();
        drive_round(2'b10, 2'b01);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({result, result_valid, Acounter, Bcounter, round_cnt, match_over, winner}
            !== {2'b00, 1'b0, 4'd0, 4'd0, 6'd0, 1'b0, 2'b00} || seg7A !== 7'b1111110) begin
            fails++;
            $display("FAIL async_reset: got res=%b a=%0d b=%0d rc=%0d seg7A=%b expected zeros, 1111110",
                     result, Acounter, Bcounter, round_cnt, seg7A);
        end
        model_clear();
        exp_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_b_wins_match();
        repeat (3) drive_round(2'b10, 2'b00);
        checks++;
        if (match_over !== 1'b1 || winner !== 2'b10 || Bcounter !== 4'd3 || fsm_state !== 1'b1) begin
            fails++;
            $display("FAIL b_wins_match: got mo=%b w=%b b=%0d st=%b expected 1 10 3 1",
                     match_over, winner, Bcounter, fsm_state);
        end
    endtask

    task automatic test_over_ignored();
        drive_round(2'b01, 2'b00);
        checks++;
        if (result_valid !== 1'b0 || Acounter !== 4'd0 || result !== 2'b10 || match_over !== 1'b1) begin
            fails++;
            $display("FAIL over_ignored: got rv=%b a=%0d res=%b mo=%b expected 0 0 10 1",
                     result_valid, Acounter, result, match_over);
        end
    endtask

    task automatic test_new_match_priority();
        @(negedge CLK);
        A = 2'b01;
        B = 2'b00;
        round_valid = 1'b1;
        new_match = 1'b1;
        @(negedge CLK);
        round_valid = 1'b0;
        new_match = 1'b0;
        model_clear();
        checks++;
        if ({result, result_valid, Acounter, Bcounter, round_cnt, match_over, winner, fsm_state}
            !== {2'b00, 1'b0, 4'd0, 4'd0, 6'd0, 1'b0, 2'b00, 1'b0}) begin
            fails++;
            $display("FAIL new_match_clear: got res=%b rv=%b a=%0d b=%0d rc=%0d mo=%b w=%b expected zeros",
                     result, result_valid, Acounter, Bcounter, round_cnt, match_over, winner);
        end
        @(negedge CLK);
        checks++;
        if (result_valid !== 1'b0 || round_cnt !== 6'd0 || Acounter !== 4'd0) begin
            fails++;
            $display("FAIL new_match_discard: got rv=%b rc=%0d a=%0d expected 0 0 0",
                     result_valid, round_cnt, Acounter);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = rv_pulses;
        @(negedge CLK);
        A = 2'b00;
        B = 2'b10;
        round_valid = 1'b1;
        repeat (4) begin
            model_round(A, B);
            @(negedge CLK);
        end
        round_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (rv_pulses - start !== 3 || Acounter !== 4'd3 || match_over !== 1'b1 || winner !== 2'b01) begin
            fails++;
            $display("FAIL back_to_back: got pulses=%0d a=%0d mo=%b w=%b expected 3 3 1 01",
                     rv_pulses - start, Acounter, match_over, winner);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] a;
        new_match_pulse();
        @(negedge CLK);
        round_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            a = 2'($urandom_range(0, 3));
            A = a;
            B = ($urandom_range(0, 1) == 1) ? a : 2'b11;
            model_round(A, B);
            @(negedge CLK);
        end
        round_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (round_cnt !== 6'd63 || Acounter !== 4'd0 || Bcounter !== 4'd0) begin
            fails++;
            $display("FAIL round_saturation: got rc=%0d a=%0d b=%0d expected 63 0 0",
                     round_cnt, Acounter, Bcounter);
        end
    endtask

    task automatic test_random();
        new_match_pulse();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                new_match_pulse();
            end else begin
                drive_round(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
        end
        @(negedge CLK);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_a_wins_round();
        test_tie_invalid();
        test_reset_mid_match();
        test_b_wins_match();
        test_over_ignored();
        test_new_match_priority();
        test_back_to_back();
        test_saturation();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending results, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
